// File: rtl/mos_switch_pair_array_if.sv
// Bundle of capture/evaluate signals for the switch-pair array.
// The master drives the switch terminals; the slave (the array) returns
// the registered node values and contention flags.
interface mos_switch_pair_array_if #(
   parameter int N = 32
);
   logic             in_valid;
   logic [2*N-1:0]   n_gate;
   logic [2*N-1:0]   n_src;
   logic [2*N-1:0]   p_gate;
   logic [2*N-1:0]   p_src;
   logic             out_valid;
   logic [2*N-1:0]   node_q;
   logic [N-1:0]     contention_q;

   modport master (
      output in_valid, n_gate, n_src, p_gate, p_src,
      input  out_valid, node_q, contention_q
   );

   modport slave (
      input  in_valid, n_gate, n_src, p_gate, p_src,
      output out_valid, node_q, contention_q
   );
endinterface

// File: rtl/mos_switch_pair_array.sv
// N independent nmos/pmos switch pairs driving a shared node per lane.
// Each lane evaluates 4-state switch conduction, resolves the wired node,
// and registers the node value plus a strong-drive contention flag.
// Lane encoding (2 bits): 00 = 0, 01 = 1, 10 = Z, 11 = X.
module mos_switch_pair_array #(
   parameter int N = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   mos_switch_pair_array_if.slave   bus
);

   localparam logic [1:0] L0 = 2'b00;
   localparam logic [1:0] L1 = 2'b01;
   localparam logic [1:0] LZ = 2'b10;
   localparam logic [1:0] LX = 2'b11;

   // An unknown gate leaves the node either floating or driven, so the
   // result is X unless the source itself is floating.
   function automatic logic [1:0] switch_out(
      input logic [1:0] gate,
      input logic [1:0] src,
      input logic [1:0] on_code,
      input logic [1:0] off_code
   );
      logic [1:0] r;
      if (gate == on_code)       r = src;
      else if (gate == off_code) r = LZ;
      else if (src == LZ)        r = LZ;
      else                       r = LX;
      return r;
   endfunction

   function automatic logic [1:0] resolve(
      input logic [1:0] a,
      input logic [1:0] b
   );
      logic [1:0] r;
      if (a == LZ)      r = b;
      else if (b == LZ) r = a;
      else if (a == b)  r = a;
      else              r = LX;
      return r;
   endfunction

   logic [2*N-1:0] node_d;
   logic [N-1:0]   cont_d;

   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [1:0] n_out;
      logic [1:0] p_out;

      assign n_out = switch_out(bus.n_gate[2*i +: 2], bus.n_src[2*i +: 2], L1, L0);
      assign p_out = switch_out(bus.p_gate[2*i +: 2], bus.p_src[2*i +: 2], L0, L1);
      assign node_d[2*i +: 2] = resolve(n_out, p_out);
      // Only two strong, opposite drives count; X outcomes are not contention.
      assign cont_d[i] = ~n_out[1] & ~p_out[1] & (n_out[0] ^ p_out[0]);
   end

   // Capture all lanes on in_valid; otherwise hold and mark output stale.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.node_q       <= {N{LZ}};
         bus.contention_q <= '0;
         bus.out_valid    <= 1'b0;
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            bus.node_q       <= node_d;
            bus.contention_q <= cont_d;
         end
      end
   end

endmodule

// File: tb/tb_mos_switch_pair_array.sv
// Self-checking bench for mos_switch_pair_array: table of single-lane
// vectors over a known background, scoreboard queue, plus hold and
// mid-stream reset sequences.
module tb_mos_switch_pair_array;

   localparam int N = 32;

   logic clk;
   logic rst_n;

   mos_switch_pair_array_if #(.N(N)) bus ();

   mos_switch_pair_array #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         lane;
      logic [1:0] ng;
      logic [1:0] ns;
      logic [1:0] pg;
      logic [1:0] ps;
      logic [1:0] node;
      logic       cont;
   } vec_t;

   typedef struct {
      logic [2*N-1:0] node;
      logic [N-1:0]   cont;
   } exp_t;

   exp_t           sb_q[$];
   exp_t           last_exp;
   vec_t           vecs[14];
   int             errors = 0;
   int             checks = 0;
   logic [2*N-1:0] all_z;
   logic [N-1:0]   no_cont;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Background: every lane is a CMOS inverter with input = lane parity,
   // so lane i reads 01 when i is even and 00 when i is odd.
   task automatic drive_vec(input vec_t v, input string name);
      exp_t e;
      exp_t got;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         bus.n_gate[2*i +: 2] = {1'b0, i[0]};
         bus.p_gate[2*i +: 2] = {1'b0, i[0]};
         bus.n_src[2*i +: 2]  = 2'b00;
         bus.p_src[2*i +: 2]  = 2'b01;
         e.node[2*i +: 2]     = i[0] ? 2'b00 : 2'b01;
      end
      e.cont = '0;
      bus.n_gate[2*v.lane +: 2] = v.ng;
      bus.n_src[2*v.lane +: 2]  = v.ns;
      bus.p_gate[2*v.lane +: 2] = v.pg;
      bus.p_src[2*v.lane +: 2]  = v.ps;
      e.node[2*v.lane +: 2]     = v.node;
      e.cont[v.lane]            = v.cont;
      bus.in_valid = 1'b1;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      chk({name, ".out_valid"}, 64'(bus.out_valid), 64'(1'b1));
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s.scoreboard: got empty queue expected one entry", name);
      end else begin
         got = sb_q.pop_front();
         last_exp = got;
         chk({name, ".node_q"}, 64'(bus.node_q), 64'(got.node));
         chk({name, ".contention_q"}, 64'(bus.contention_q), 64'(got.cont));
      end
   endtask

   task automatic hold_cycle(input string name);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.n_gate = {$urandom, $urandom};
      bus.n_src  = {$urandom, $urandom};
      bus.p_gate = {$urandom, $urandom};
      bus.p_src  = {$urandom, $urandom};
      @(posedge clk);
      #1;
      chk({name, ".out_valid"}, 64'(bus.out_valid), 64'(1'b0));
      chk({name, ".node_q"}, 64'(bus.node_q), 64'(last_exp.node));
      chk({name, ".contention_q"}, 64'(bus.contention_q), 64'(last_exp.cont));
   endtask

   task automatic chk_reset_state(input string name);
      chk({name, ".node_q"}, 64'(bus.node_q), 64'(all_z));
      chk({name, ".contention_q"}, 64'(bus.contention_q), 64'(no_cont));
      chk({name, ".out_valid"}, 64'(bus.out_valid), 64'(1'b0));
   endtask

   // Reset asserted between edges, held across an edge with in_valid high,
   // then released and followed by a fresh capture.
   task automatic mid_reset(input vec_t v, input string name);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_state({name, ".immediate"});
      @(negedge clk);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk_reset_state({name, ".held"});
      rst_n = 1'b1;
      drive_vec(v, {name, ".recapture"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //          lane ng     ns     pg     ps     node   cont
      vecs[0]  = '{0,  2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 1'b0}; // inverter x=0
      vecs[1]  = '{0,  2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0}; // inverter x=1
      vecs[2]  = '{0,  2'b10, 2'b00, 2'b10, 2'b01, 2'b11, 1'b0}; // inverter x=Z
      vecs[3]  = '{0,  2'b11, 2'b00, 2'b11, 2'b01, 2'b11, 1'b0}; // inverter x=X
      vecs[4]  = '{0,  2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 1'b0}; // both off
      vecs[5]  = '{0,  2'b11, 2'b10, 2'b11, 2'b10, 2'b10, 1'b0}; // gates X, srcs Z
      vecs[6]  = '{0,  2'b01, 2'b00, 2'b00, 2'b01, 2'b11, 1'b1}; // contention 0 vs 1
      vecs[7]  = '{0,  2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 1'b0}; // both drive 1
      vecs[8]  = '{31, 2'b01, 2'b01, 2'b00, 2'b00, 2'b11, 1'b1}; // contention 1 vs 0
      vecs[9]  = '{31, 2'b01, 2'b11, 2'b01, 2'b00, 2'b11, 1'b0}; // pass X, p off
      vecs[10] = '{31, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0}; // X with 0
      vecs[11] = '{5,  2'b01, 2'b10, 2'b00, 2'b01, 2'b01, 1'b0}; // Z with 1
      vecs[12] = '{17, 2'b10, 2'b01, 2'b01, 2'b00, 2'b11, 1'b0}; // gate Z, src 1
      vecs[13] = '{0,  2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 1'b0}; // n off, p X gate Z src

      all_z   = {N{2'b10}};
      no_cont = '0;

      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.n_gate   = '0;
      bus.n_src    = '0;
      bus.p_gate   = '0;
      bus.p_src    = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_state("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < 14; k++)
         drive_vec(vecs[k], $sformatf("vec%0d", k));

      drive_vec(vecs[0], "hold_load");
      for (int k = 0; k < 3; k++)
         hold_cycle($sformatf("hold%0d", k));

      drive_vec(vecs[6], "pre_reset0");
      mid_reset(vecs[1], "mid_reset_lane0");
      drive_vec(vecs[8], "pre_reset31");
      mid_reset(vecs[10], "mid_reset_lane31");

      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("final.out_valid", 64'(bus.out_valid), 64'(1'b0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
